// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: parity modes, stop-bit count
// and the transmit FSM states, plus the parity helpers used at byte capture.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE0 = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_NONE3 = 2'b11
    } parity_e;

    typedef enum logic {
        STOP_ONE = 1'b0,
        STOP_TWO = 1'b1
    } stop_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic logic parity_enabled(input parity_e mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

    // Odd parity makes the total count of ones (data + parity) odd.
    function automatic logic parity_bit(input logic [7:0] data, input parity_e mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each
// serial bit. Held at zero while clear is asserted.
module uart_baud_counter #(
    parameter  int CLKS_PER_BIT = 16,
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             bit_tick
);

    assign bit_tick = (count == CNT_W'(CLKS_PER_BIT - 1));

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || bit_tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, 8 data bits LSB first, optional
// parity and 1 or 2 stop bits, one byte per valid/ready handshake.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e        state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    stop_e            stop_cfg_q, stop_cfg_d;
    logic             tx_out_d, tx_done_d;
    logic [CNT_W-1:0] baud_count;
    logic             bit_tick;
    logic             last_stop;

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_q == IDLE),
        .count    (baud_count),
        .bit_tick (bit_tick)
    );

    assign last_stop = (stop_cfg_q == STOP_ONE) || stop_idx_q;

    // NOTE: every signal gets a default first so no branch can infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop_cfg_d = stop_cfg_q;
        tx_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_d    = START;
                    shift_d    = tx_data;
                    bit_idx_d  = 3'd0;
                    stop_idx_d = 1'b0;
                    par_en_d   = parity_enabled(parity_e'(parity_type));
                    par_bit_d  = parity_bit(tx_data, parity_e'(parity_type));
                    stop_cfg_d = stop_e'(stop_bits);
                end
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
            STOP: begin
                // Registered pulse: raise it one clock early so it lands on the final clock.
                tx_done_d = last_stop && (baud_count == CNT_W'(CLKS_PER_BIT - 2));
                if (bit_tick) begin
                    if (last_stop) state_d    = IDLE;
                    else           stop_idx_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = par_bit_q;
            default: tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_cfg_q <= STOP_ONE;
            tx_out     <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop_cfg_q <= stop_cfg_d;
            tx_out     <= tx_out_d;
            tx_ready   <= (state_d == IDLE);
            tx_busy    <= (state_d != IDLE);
            tx_done    <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: table of frames with hand-built line
// patterns, plus reset, back-to-back and input-hold corner sequences.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  ptype;
        logic        stop;
        logic [11:0] frame;   // line value per bit period, bit 0 = start bit
        int          nbits;
    } vec_t;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[7];

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .tx_out      (tx_out),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic actual, input logic expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " tx_out"},   tx_out,   1'b1);
        check({tag, " tx_ready"}, tx_ready, 1'b1);
        check({tag, " tx_busy"},  tx_busy,  1'b0);
        check({tag, " tx_done"},  tx_done,  1'b0);
    endtask

    // Entered #1 after the accepting edge; leaves #1 after the edge back into IDLE.
    task automatic check_frame(input logic [11:0] frame, input int nbits, input bit scramble);
        int          len;
        logic [11:0] f;
        len = nbits * CPB;
        for (int c = 1; c <= len; c++) begin
            f = frame >> ((c - 1) / CPB);
            check("frame tx_out",   tx_out,   f[0]);
            check("frame tx_done",  tx_done,  c == len);
            check("frame tx_busy",  tx_busy,  1'b1);
            check("frame tx_ready", tx_ready, 1'b0);
            if (scramble && c == len / 2) begin
                tx_data     = ~tx_data;
                parity_type = ~parity_type;
                stop_bits   = ~stop_bits;
            end
            @(posedge clock); #1;
        end
        check_idle("post-frame");
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("wait_ready", tx_ready, 1'b1);
    endtask

    task automatic send(input vec_t v, input bit scramble);
        wait_ready();
        tx_data     = v.data;
        parity_type = v.ptype;
        stop_bits   = v.stop;
        tx_valid    = 1'b1;
        @(posedge clock); #1;
        tx_valid = 1'b0;
        check_frame(v.frame, v.nbits, scramble);
    endtask

    initial begin
        vecs[0] = '{data: 8'h55, ptype: 2'b00, stop: 1'b0, frame: 12'h2AA, nbits: 10};
        vecs[1] = '{data: 8'h07, ptype: 2'b01, stop: 1'b0, frame: 12'h40E, nbits: 11};
        vecs[2] = '{data: 8'h07, ptype: 2'b10, stop: 1'b0, frame: 12'h60E, nbits: 11};
        vecs[3] = '{data: 8'h00, ptype: 2'b10, stop: 1'b1, frame: 12'hC00, nbits: 12};
        vecs[4] = '{data: 8'hA3, ptype: 2'b11, stop: 1'b1, frame: 12'h746, nbits: 11};
        vecs[5] = '{data: 8'h3C, ptype: 2'b01, stop: 1'b0, frame: 12'h678, nbits: 11};
        vecs[6] = '{data: 8'hFF, ptype: 2'b01, stop: 1'b1, frame: 12'hFFE, nbits: 12};

        reset       = 1'b1;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        #3;
        check_idle("in-reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Valid low: the line must stay high.
        repeat (6) @(posedge clock);
        #1 check_idle("quiet");

        for (int i = 0; i < 7; i++) begin
            send(vecs[i], (i % 2) == 1);
        end

        // Asynchronous reset in the middle of the data bits of a 0x55 frame.
        tx_data     = 8'h55;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        tx_valid    = 1'b1;
        @(posedge clock); #1;
        tx_valid = 1'b0;
        repeat (14) @(posedge clock);
        #2 reset = 1'b1;
        #1 check_idle("async-reset");
        @(posedge clock); #1;
        check_idle("held-reset");
        reset = 1'b0;
        @(posedge clock); #1;
        check_idle("after-reset");
        send(vecs[0], 1'b0);

        // Back-to-back: valid stays high, second byte queued right after capture.
        wait_ready();
        tx_data     = 8'hA3;
        parity_type = 2'b11;
        stop_bits   = 1'b1;
        tx_valid    = 1'b1;
        @(posedge clock); #1;
        tx_data     = 8'h3C;
        parity_type = 2'b01;
        stop_bits   = 1'b0;
        check_frame(vecs[4].frame, vecs[4].nbits, 1'b0);
        @(posedge clock); #1;
        tx_valid = 1'b0;
        check_frame(vecs[5].frame, vecs[5].nbits, 1'b0);

        repeat (3) @(posedge clock);
        #1 check_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
